insn_encoder: RTL and testbench

//  Immediate/instruction encoder: inverse of the immediate extractor. Packs opcode, registers, funct

---
 rtl/insn_encoder.sv | 162 ++++++++++++++++
 tb/tb_insn_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/insn_encoder.sv
// insn_encoder: packs opcode, register, funct and immediate fields into an
// RV32I instruction word. It also expands the LI pseudo-op into LUI, LUI+ADDI
// or a single ADDI.
//
// Handshake: a request is taken on a clock edge where in_valid & in_ready.
// A word is consumed on a clock edge where out_valid & out_ready.
// While out_valid & ~out_ready, out_insn and out_err do not change.
// There is one output register, so an accepted request appears on the outputs
// after the edge that accepted it.
//
// Optional feature: when ENC_RANGE_CHECK_EN is defined, out_err reports
// immediates that are out of range and opcodes that are not supported.
// Without the macro, out_err is tied to 0 and no range logic is built.
// dbg_state shows the FSM state: 0 = IDLE, 1 = LI_LO (ADDI half of LI pending).
module insn_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_li,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_err,
  output logic        dbg_state
);

  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [31:0] NOP        = 32'h00000013;

  typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        accept, take;
  logic [31:0] enc_insn;
  logic        enc_err;
  logic        li_fits, li_need_lo;
  logic [19:0] li_hi;
  logic [31:0] li_word;
  logic [4:0]  li_rd;
  logic [11:0] li_lo;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // Plain field packing for each supported opcode. Unsupported opcodes produce a NOP.
  always_comb begin
    enc_insn = NOP;
    case (in_opcode)
      OPC_LUI, OPC_AUIPC:
        enc_insn = {in_imm[31:12], in_rd, in_opcode};
      OPC_JAL:
        enc_insn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      OPC_JALR, OPC_OP_IMM, OPC_LOAD:
        enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OPC_BRANCH:
        enc_insn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], in_opcode};
      OPC_STORE:
        enc_insn = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OPC_OP:
        enc_insn = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default:
        enc_insn = NOP;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Range rules: the immediate must be representable in the field it is truncated into.
  always_comb begin
    enc_err = 1'b0;
    case (in_opcode)
      OPC_LUI, OPC_AUIPC:
        enc_err = |in_imm[11:0];
      OPC_JAL:
        enc_err = (in_imm[31:20] != {12{in_imm[20]}}) | in_imm[0];
      OPC_JALR, OPC_OP_IMM, OPC_LOAD, OPC_STORE:
        enc_err = (in_imm[31:11] != {21{in_imm[11]}});
      OPC_BRANCH:
        enc_err = (in_imm[31:12] != {20{in_imm[12]}}) | in_imm[0];
      OPC_OP:
        enc_err = 1'b0;
      default:
        enc_err = 1'b1;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  // LI expansion. The upper part is rounded so that the ADDI's sign-extended
  // low 12 bits add back to the full value. (imm + 0x800) >> 12 equals imm[31:12] + imm[11].
  assign li_fits    = (in_imm[31:11] == {21{in_imm[11]}});
  assign li_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
  assign li_need_lo = ~li_fits & (|in_imm[11:0]);
  assign li_word    = li_fits ? {in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_OP_IMM}
                              : {li_hi, in_rd, OPC_LUI};

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: go to LI_LO only for an LI that needs a second word,
  // and return to IDLE once the LUI word has been taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && in_li && li_need_lo) state_nxt = LI_LO;
      LI_LO:   if (take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accept requests only when idle and the output register is free or draining.
  always_comb begin
    in_ready  = rst_n & (state == IDLE) & (~out_valid | out_ready);
    dbg_state = (state == LI_LO);
  end

  // Output register and the latched LI fields for the pending ADDI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_insn  <= 32'd0;
      out_err   <= 1'b0;
      li_rd     <= 5'd0;
      li_lo     <= 12'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_insn  <= in_li ? li_word : enc_insn;
      out_err   <= in_li ? 1'b0 : enc_err;
      if (in_li) begin
        li_rd <= in_rd;
        li_lo <= in_imm[11:0];
      end
    end else if (state == LI_LO && take) begin
      out_valid <= 1'b1;
      out_insn  <= {li_lo, li_rd, 3'b000, li_rd, OPC_OP_IMM};
      out_err   <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: directed vectors for insn_encoder with hand-computed words.
// Expected {err, insn} pairs are queued when a request is issued. A monitor
// pops and compares one entry for each word the DUT hands over. Inputs change
// at posedge + 1; the monitor samples at negedge.
module tb_insn_encoder;

`ifdef ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_li = 1'b0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_insn;
  logic        out_err;
  logic        dbg_state;

  logic [32:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          waits;

  insn_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_li(in_li),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_err(out_err),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] insn, input logic err);
    exp_q.push_back({err, insn});
  endtask

  // Drive one request (called at posedge+1); returns at posedge+1 after the accepting edge.
  task automatic send(input logic li, input logic [6:0] opc, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, output int w);
    in_valid = 1'b1; in_li = li; in_opcode = opc; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    w = 0;
    #1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) check("send_timeout", 32'(w), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: one queue entry per word taken by the consumer.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h err %b, expected no output", out_insn, out_err);
        end else begin
          e = exp_q.pop_front();
          check("out_insn", out_insn, e[31:0]);
          check("out_err", {31'd0, out_err}, {31'd0, e[32]});
        end
      end
    end
  end

  // Stimulus
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_insn", out_insn, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Main encodings, full throughput
    expect_word(32'h123452B7, 1'b0); send(0, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, waits);
    expect_word(32'hFFF00093, 1'b0); send(0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, waits);
    expect_word(32'h00208463, 1'b0); send(0, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000008, waits);
    check("no_bubble", 32'(waits), 32'd0);
    expect_word(32'hFE512E23, 1'b0); send(0, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFFFFFC, waits);
    expect_word(32'h001000EF, 1'b0); send(0, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, waits);
    expect_word(32'hFFFFF06F, 1'b0); send(0, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFE, waits);
    expect_word(32'h403100B3, 1'b0); send(0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'h0, waits);
    expect_word(32'hFE209CE3, 1'b0); send(0, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFFFFF8, waits);
    expect_word(32'h010280E7, 1'b0); send(0, 7'b1100111, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 32'h00000010, waits);
    expect_word(32'h7FF12303, 1'b0); send(0, 7'b0000011, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, 32'h000007FF, waits);

    // Range violations and an unsupported opcode
    expect_word(32'h80000013, RC);   send(0, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, waits);
    expect_word(32'h00000013, RC);   send(0, 7'b1111111, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, waits);
    expect_word(32'h00001197, RC);   send(0, 7'b0010111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, waits);
    expect_word(32'h00000263, RC);   send(0, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000005, waits);
    expect_word(32'h00000023, RC);   send(0, 7'b0100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, waits);
    idle(3);

    // LI that needs two words, with the consumer stalled for 3 cycles
    out_ready = 1'b0;
    expect_word(32'h12346537, 1'b0);
    expect_word(32'hFFF50513, 1'b0);
    send(1, 7'b0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, waits);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_insn", out_insn, 32'h12346537);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("li_lo_in_ready", {31'd0, in_ready}, 32'd0);
    check("li_lo_state", {31'd0, dbg_state}, 32'd1);
    @(posedge clk); #1;

    // LI with zero low bits, then LI that fits 12 bits (opcode input ignored)
    expect_word(32'h00003537, 1'b0); send(1, 7'b1111111, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00003000, waits);
    expect_word(32'h80000013, 1'b0); send(1, 7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, waits);
    idle(4);

    // Reset one cycle after the LUI half of an LI is accepted
    out_ready = 1'b0;
    send(1, 7'b0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, waits);
    in_valid = 1'b0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    idle(5);
    expect_word(32'h00100093, 1'b0); send(0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000001, waits);
    idle(1);

    // Drain and confirm that every expected word appeared
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
